punct_conv_encoder: RTL and testbench

Parametrised successor to the rate-1/2 TX convolutional encoder. It adds selectable puncturing for 802.11a rates 1/2, 2/3 and 3/4, a valid/ready input handshake, and a single-clock serial output. There is no derived slow clock. It sits between the scrambler/data source and the interleaver in the TX chain. It takes one data bit per handshake and emits the kept coded bits one per clock.

---
 rtl/enc_pkg.sv | 29 ++
 rtl/conv_core.sv | 36 +++
 rtl/punct_conv_encoder.sv | 101 ++++++++++
 tb/tb_punct_conv_encoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and helpers for the punctured convolutional encoder
package enc_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_2_3 = 2'b01;
  localparam logic [1:0] RATE_3_4 = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT1 = 2'd1;
  localparam logic [1:0] ST_EMIT2 = 2'd2;

  localparam int         K_DEFAULT  = 7;
  localparam logic [6:0] G0_DEFAULT = 7'o133;
  localparam logic [6:0] G1_DEFAULT = 7'o171;

  // The reserved code 11 behaves as unpunctured 1/2.
  function automatic logic [1:0] norm_rate(input logic [1:0] rate);
    return (rate == RATE_2_3 || rate == RATE_3_4) ? rate : RATE_1_2;
  endfunction

  function automatic logic [1:0] last_phase(input logic [1:0] rate);
    case (rate)
      RATE_2_3: return 2'd1;
      RATE_3_4: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_core.sv
// rtl/conv_core.sv - shift register and generator XOR trees of the convolutional code
module conv_core
  import enc_pkg::*;
#(
  parameter int         K  = K_DEFAULT,
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic clr,
  input  logic din,
  output logic a,
  output logic b
);

  logic [K-2:0] sr;
  logic [K-1:0] window;

  // sr[K-2] is the most recent previous bit, so the current bit sits on the MSB tap.
  assign window = {din, sr};
  assign a      = ^(window & G0);
  assign b      = ^(window & G1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (shift_en) begin
      sr <= {din, sr[K-2:1]};
    end
  end

endmodule

// File: rtl/punct_conv_encoder.sv
// rtl/punct_conv_encoder.sv - rate 1/2, 2/3, 3/4 punctured convolutional encoder with serial output
module punct_conv_encoder
  import enc_pkg::*;
#(
  parameter int           K  = K_DEFAULT,
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEN,
  input  logic       iValid,
  input  logic       iData,
  input  logic       iLast,
  input  logic [1:0] iRate,
  output logic       oReady,
  output logic       oData,
  output logic       oValid,
  output logic       oLast
);

  logic [1:0] state;
  logic [1:0] phase;
  logic [1:0] rate_q;
  logic [1:0] cur_rate;
  logic [1:0] phase_nxt;
  logic       data_q;
  logic       pend_b;
  logic       last_q;
  logic       accept;
  logic       bit_a;
  logic       bit_b;

  // EMIT1 also accepts so a single-bit tail overlaps the next load without a bubble.
  assign oReady = !iRst && iEN && (state == ST_IDLE || state == ST_EMIT1);
  assign accept = iEN && iValid && oReady;

  // A fresh rate is taken only at the start of a puncture period.
  assign cur_rate  = (phase == 2'd0) ? norm_rate(iRate) : rate_q;
  assign phase_nxt = (phase == last_phase(cur_rate)) ? 2'd0 : phase + 2'd1;

  conv_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk      (iClk),
    .rst      (iRst),
    .shift_en (accept),
    .clr      (accept && iLast),
    .din      (iData),
    .a        (bit_a),
    .b        (bit_b)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= ST_IDLE;
      phase  <= 2'd0;
      rate_q <= RATE_1_2;
      data_q <= 1'b0;
      pend_b <= 1'b0;
      last_q <= 1'b0;
    end else if (iEN) begin
      if (accept) begin
        rate_q <= cur_rate;
        phase  <= iLast ? 2'd0 : phase_nxt;
        last_q <= iLast;
        case (phase)
          2'd0: begin
            data_q <= bit_a;
            pend_b <= bit_b;
            state  <= ST_EMIT2;
          end
          2'd1: begin
            data_q <= bit_a;
            state  <= ST_EMIT1;
          end
          default: begin
            data_q <= bit_b;
            state  <= ST_EMIT1;
          end
        endcase
      end else begin
        case (state)
          ST_EMIT2: begin
            data_q <= pend_b;
            state  <= ST_EMIT1;
          end
          ST_EMIT1: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign oData  = data_q;
  assign oValid = iEN && (state != ST_IDLE);
  assign oLast  = oValid && (state == ST_EMIT1) && last_q;

endmodule

// File: tb/tb_punct_conv_encoder.sv
// tb/tb_punct_conv_encoder.sv - self-checking bench for punct_conv_encoder
module tb_punct_conv_encoder;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iEN = 1'b1;
  logic       iValid = 1'b0;
  logic       iData = 1'b0;
  logic       iLast = 1'b0;
  logic [1:0] iRate = 2'b00;
  logic       oReady, oData, oValid, oLast;

  punct_conv_encoder dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iEN    (iEN),
    .iValid (iValid),
    .iData  (iData),
    .iLast  (iLast),
    .iRate  (iRate),
    .oReady (oReady),
    .oData  (oData),
    .oValid (oValid),
    .oLast  (oLast)
  );

  initial forever #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed stream: {data, last} and the cycle each bit appeared in.
  logic [1:0] got_q[$];
  int         got_cyc[$];
  logic [1:0] exp_q[$];

  always @(negedge iClk) begin
    if (oValid === 1'b1) begin
      got_q.push_back({oData, oLast});
      got_cyc.push_back(cyc);
    end
  end

  // Reference model: history of packet bits, generators applied by direct summation.
  logic [6:0] g0 = 7'o133;
  logic [6:0] g1 = 7'o171;
  logic       m_hist[$];
  int         m_phase = 0;
  int         m_rate = 0;

  function automatic void model_reset();
    m_hist.delete();
    m_phase = 0;
    m_rate  = 0;
  endfunction

  function automatic void model_push(input logic d, input logic last, input logic [1:0] rate);
    logic a, b;
    int   n;
    if (m_phase == 0) m_rate = (rate == 2'b11) ? 0 : int'(rate);
    m_hist.push_back(d);
    n = m_hist.size();
    a = 1'b0;
    b = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (j < n) begin
        a = a ^ (m_hist[n-1-j] & g0[6-j]);
        b = b ^ (m_hist[n-1-j] & g1[6-j]);
      end
    end
    if (m_phase == 0) begin
      exp_q.push_back({a, 1'b0});
      exp_q.push_back({b, last});
    end else if (m_phase == 1) begin
      exp_q.push_back({a, last});
    end else begin
      exp_q.push_back({b, last});
    end
    m_phase = (m_phase + 1) % (m_rate + 1);
    if (last) begin
      m_hist.delete();
      m_phase = 0;
    end
  endfunction

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  int last_acc = 0;

  task automatic send_bit(input logic d, input logic last, input logic [1:0] rate);
    bit done = 1'b0;
    iData  = d;
    iLast  = last;
    iRate  = rate;
    iValid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge iClk);
      if (oReady) begin
        last_acc = cyc;
        model_push(d, last, rate);
        @(posedge iClk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check_int("accept timeout", 0, 1);
  endtask

  task automatic go_idle();
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 60 && quiet < 4; i++) begin
      @(negedge iClk);
      if (oValid) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) check_int("drain timeout", quiet, 4);
  endtask

  task automatic clear_streams();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    go_idle();
    @(posedge iClk);
    #1;
    iRst = 1'b1;
    #1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    model_reset();
    clear_streams();
  endtask

  task automatic compare_stream(input string name);
    check_int({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_int($sformatf("%s bit%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
  endtask

  typedef struct {
    logic [1:0] rate;
    int         n_in;
    logic [2:0] din;
    int         n_out;
    logic [5:0] dout;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int first_acc;
    int gaps;
    int n_last;

    vecs[0] = '{rate: 2'b00, n_in: 3, din: 3'b111, n_out: 6, dout: 6'b100111};
    vecs[1] = '{rate: 2'b01, n_in: 2, din: 3'b011, n_out: 3, dout: 6'b000111};
    vecs[2] = '{rate: 2'b10, n_in: 3, din: 3'b111, n_out: 4, dout: 6'b001111};

    // Reset state
    #2;
    check_int("rst oReady", oReady, 0);
    check_int("rst oValid", oValid, 0);
    check_int("rst oData", oData, 0);
    check_int("rst oLast", oLast, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    #1;
    check_int("idle oReady", oReady, 1);

    // Fixed vectors at each rate
    for (int v = 0; v < 3; v++) begin
      do_reset();
      first_acc = 0;
      for (int i = 0; i < vecs[v].n_in; i++) begin
        send_bit(vecs[v].din[i], 1'b0, vecs[v].rate);
        if (i == 0) first_acc = last_acc;
      end
      go_idle();
      drain();
      check_int($sformatf("vec%0d count", v), got_q.size(), vecs[v].n_out);
      for (int i = 0; i < got_q.size() && i < vecs[v].n_out; i++)
        check_int($sformatf("vec%0d bit%0d", v, i), got_q[i][1], vecs[v].dout[i]);
      check_int($sformatf("vec%0d latency", v), (got_cyc.size() > 0) ? got_cyc[0] : -1, first_acc + 1);
      gaps = 0;
      for (int i = 1; i < got_cyc.size(); i++)
        if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
      check_int($sformatf("vec%0d gaps", v), gaps, 0);
    end

    // Continuous random stream at 3/4
    do_reset();
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 2'b10);
    go_idle();
    drain();
    check_int("r34 total", got_q.size(), 16);
    compare_stream("r34");
    gaps = 0;
    for (int i = 1; i < got_cyc.size(); i++)
      if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    check_int("r34 gaps", gaps, 0);

    // Rate change inside a puncture period
    do_reset();
    send_bit(1'b1, 1'b0, 2'b10);
    send_bit(1'b0, 1'b0, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    go_idle();
    drain();
    check_int("ratechg total", got_q.size(), 8);
    compare_stream("ratechg");

    // iLast at phase 0 of rate 2/3, then a fresh packet
    do_reset();
    send_bit(1'b1, 1'b0, 2'b01);
    send_bit(1'b0, 1'b0, 2'b01);
    send_bit(1'b1, 1'b1, 2'b01);
    send_bit(1'b1, 1'b0, 2'b01);
    send_bit(1'b1, 1'b0, 2'b01);
    go_idle();
    drain();
    compare_stream("last");
    n_last = 0;
    foreach (got_q[i]) if (got_q[i][0]) n_last++;
    check_int("last count", n_last, 1);
    check_int("last pos", (got_q.size() > 4) ? int'(got_q[4][0]) : 0, 1);

    // Random rates with random stalls against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        repeat ($urandom_range(1, 3)) @(posedge iClk);
        #1;
      end
    end
    go_idle();
    drain();
    compare_stream("rand");

    // iEN gap during EMIT2
    do_reset();
    send_bit(1'b1, 1'b0, 2'b00);
    go_idle();
    iEN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk);
      check_int($sformatf("en gap oValid%0d", i), oValid, 0);
      check_int($sformatf("en gap oReady%0d", i), oReady, 0);
    end
    @(posedge iClk);
    #1;
    iEN = 1'b1;
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b0, 1'b1, 2'b00);
    go_idle();
    drain();
    compare_stream("en gap");

    // Reset during emission, then encoding restarts from a zero state
    clear_streams();
    send_bit(1'b1, 1'b0, 2'b00);
    go_idle();
    check_int("pre rst oData", oData, 1);
    check_int("pre rst oValid", oValid, 1);
    iRst = 1'b1;
    #1;
    check_int("mid rst oValid", oValid, 0);
    check_int("mid rst oData", oData, 0);
    check_int("mid rst oReady", oReady, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    model_reset();
    clear_streams();
    send_bit(1'b1, 1'b0, 2'b00);
    send_bit(1'b1, 1'b0, 2'b00);
    go_idle();
    drain();
    check_int("post rst first", (got_q.size() > 0) ? int'(got_q[0][1]) : 0, 1);
    compare_stream("post rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
